// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : RV32I decode stage. Classifies the instruction format,
//                builds the sign-extended immediate, reads the 32x32
//                register file, tracks in-flight writes per register and
//                raises data_hazard so fetch replays the same pc/inst pair.
//                Results land in the execute pipe register (1-cycle latency).
//  Option      : define DECODE_WB_BYPASS_EN to forward wb_data to a source
//                operand whose last outstanding write retires this cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int PEND_W = 2,
  parameter int XLEN   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     if_pc,
  input  logic [31:0]     if_inst,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            data_hazard,
  output logic            ex_valid,
  output logic [31:0]     ex_pc,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_we,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [XLEN-1:0]   rf  [32];
  logic [PEND_W-1:0] cnt [32];

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic            inst_valid, use_rs1, use_rs2, writes_rd;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            byp_rs1, byp_rs2;
  logic            haz_rs1, haz_rs2, rd_full;
  logic            reg_we, issue, do_inc;

  assign opcode = if_inst[6:0];
  assign rd     = if_inst[11:7];
  assign rs1    = if_inst[19:15];
  assign rs2    = if_inst[24:20];

  // Format classification: which sources are read, whether rd is written,
  // and which immediate layout applies. Unknown opcodes decode as bubbles.
  always_comb begin
    inst_valid = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    writes_rd  = 1'b0;
    imm        = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        inst_valid = 1'b1;
        writes_rd  = 1'b1;
        imm        = {if_inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        inst_valid = 1'b1;
        writes_rd  = 1'b1;
        imm        = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                      if_inst[20], if_inst[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        inst_valid = 1'b1;
        use_rs1    = 1'b1;
        writes_rd  = 1'b1;
        imm        = {{20{if_inst[31]}}, if_inst[31:20]};
      end
      OPC_BRANCH: begin
        inst_valid = 1'b1;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        imm        = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                      if_inst[30:25], if_inst[11:8], 1'b0};
      end
      OPC_STORE: begin
        inst_valid = 1'b1;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        imm        = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
      end
      OPC_OP: begin
        inst_valid = 1'b1;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        writes_rd  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef DECODE_WB_BYPASS_EN
  // A source whose only outstanding write retires this cycle is not a hazard.
  assign byp_rs1 = wb_we && (wb_rd == rs1) && (cnt[rs1] == CNT_ONE);
  assign byp_rs2 = wb_we && (wb_rd == rs2) && (cnt[rs2] == CNT_ONE);
`else
  assign byp_rs1 = 1'b0;
  assign byp_rs2 = 1'b0;
`endif

  assign haz_rs1     = use_rs1 && (rs1 != 5'd0) && (cnt[rs1] != '0) && !byp_rs1;
  assign haz_rs2     = use_rs2 && (rs2 != 5'd0) && (cnt[rs2] != '0) && !byp_rs2;
  assign rd_full     = writes_rd && (rd != 5'd0) && (cnt[rd] == CNT_MAX);
  assign data_hazard = haz_rs1 || haz_rs2 || rd_full;

  assign reg_we = writes_rd && (rd != 5'd0);
  assign issue  = inst_valid && !data_hazard;
  assign do_inc = issue && reg_we;

  // Source operand read: x0 and unused sources give 0; a same-cycle write
  // is only visible here when writeback forwarding is built in.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (use_rs1 && (rs1 != 5'd0)) begin
      rs1_val = rf[rs1];
`ifdef DECODE_WB_BYPASS_EN
      if (wb_we && (wb_rd == rs1)) rs1_val = wb_data;
`endif
    end
    if (use_rs2 && (rs2 != 5'd0)) begin
      rs2_val = rf[rs2];
`ifdef DECODE_WB_BYPASS_EN
      if (wb_we && (wb_rd == rs2)) rs2_val = wb_data;
`endif
    end
  end

  // Register file: cleared on reset, written by writeback (x0 never written).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we && (wb_rd != 5'd0)) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // In-flight write counters: +1 on issue, -1 on writeback, hold when both
  // hit the same register; a writeback to an idle register leaves it at 0.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 32; r++) begin
      if (rst || (r == 0)) begin
        cnt[r] <= '0;
      end else if (do_inc && (rd == 5'(r))) begin
        if (!(wb_we && (wb_rd == 5'(r)))) cnt[r] <= cnt[r] + CNT_ONE;
      end else if (wb_we && (wb_rd == 5'(r)) && (cnt[r] != '0)) begin
        cnt[r] <= cnt[r] - CNT_ONE;
      end
    end
  end

  // Execute pipe register: loads the decoded instruction on issue, a
  // cleared bubble on reset, hazard or bubble input.
  always_ff @(posedge clk) begin
    if (rst || !issue) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_rd       <= '0;
      ex_reg_we   <= 1'b0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
    end else begin
      ex_valid    <= 1'b1;
      ex_pc       <= if_pc;
      ex_opcode   <= opcode;
      ex_funct3   <= if_inst[14:12];
      ex_funct7b5 <= if_inst[30];
      ex_rd       <= reg_we ? rd : 5'd0;
      ex_reg_we   <= reg_we;
      ex_rs1_data <= rs1_val;
      ex_rs2_data <= rs2_val;
      ex_imm      <= imm;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage. Instructions are built
//                from assembly-level fields (kind, registers, immediate value)
//                and compared against a register/pending-write model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  localparam int PEND_W = 2;
  localparam int PMAX   = (1 << PEND_W) - 1;

  localparam int K_NONE = 0;
  localparam int K_U    = 1;
  localparam int K_J    = 2;
  localparam int K_I    = 3;
  localparam int K_B    = 4;
  localparam int K_S    = 5;
  localparam int K_R    = 6;

  typedef struct {
    int          kind;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] inst;
    logic [31:0] pc;
  } desc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, if_inst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        data_hazard, ex_valid, ex_funct7b5, ex_reg_we;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;

  int checks = 0;
  int errors = 0;

  // reference model: architectural registers, pending writes, issue order
  logic [31:0] regs [32];
  int          pend [32];
  logic [4:0]  inflight [$];

  always #5 clk = ~clk;

  decode_stage #(.PEND_W(PEND_W), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .data_hazard(data_hazard), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Assemble an instruction from its fields; r supplies the immediate bits.
  function automatic desc_t mk(input int kind, input logic [6:0] op,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [31:0] r);
    desc_t d;
    d.kind = kind; d.rd = rd; d.rs1 = rs1; d.rs2 = rs2; d.f3 = f3; d.pc = '0;
    case (kind)
      K_U: begin
        d.imm  = {r[31:12], 12'b0};
        d.inst = {d.imm[31:12], rd, op};
      end
      K_J: begin
        d.imm  = {{11{r[20]}}, r[20:1], 1'b0};
        d.inst = {d.imm[20], d.imm[10:1], d.imm[11], d.imm[19:12], rd, op};
      end
      K_I: begin
        d.imm  = {{20{r[11]}}, r[11:0]};
        d.inst = {d.imm[11:0], rs1, f3, rd, op};
      end
      K_S: begin
        d.imm  = {{20{r[11]}}, r[11:0]};
        d.inst = {d.imm[11:5], rs2, rs1, f3, d.imm[4:0], op};
      end
      K_B: begin
        d.imm  = {{19{r[12]}}, r[12:1], 1'b0};
        d.inst = {d.imm[12], d.imm[10:5], rs2, rs1, f3, d.imm[4:1], d.imm[11], op};
      end
      K_R: begin
        d.imm  = '0;
        d.inst = {1'b0, r[30], 5'b0, rs2, rs1, f3, rd, op};
      end
      default: begin
        d.imm  = '0;
        d.inst = (op == 7'd0) ? 32'd0 : {r[31:7], op};
      end
    endcase
    return d;
  endfunction

  function automatic desc_t gen();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] r;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    r   = $urandom;
    case ($urandom_range(0, 10))
      0:       return mk(K_U, 7'h37, rd, rs1, rs2, f3, r);
      1:       return mk(K_U, 7'h17, rd, rs1, rs2, f3, r);
      2:       return mk(K_J, 7'h6f, rd, rs1, rs2, f3, r);
      3:       return mk(K_I, 7'h67, rd, rs1, rs2, f3, r);
      4:       return mk(K_I, 7'h03, rd, rs1, rs2, f3, r);
      5:       return mk(K_I, 7'h13, rd, rs1, rs2, f3, r);
      6:       return mk(K_B, 7'h63, rd, rs1, rs2, f3, r);
      7:       return mk(K_S, 7'h23, rd, rs1, rs2, f3, r);
      8:       return mk(K_R, 7'h33, rd, rs1, rs2, f3, r);
      9:       return mk(K_NONE, 7'h00, rd, rs1, rs2, f3, r);
      default: return mk(K_NONE, 7'h7f, rd, rs1, rs2, f3, r);
    endcase
  endfunction

  function automatic logic blocked(input logic [4:0] rs, input logic we, input logic [4:0] wrd);
    if (rs == 5'd0 || pend[rs] == 0) return 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    if (we && wrd == rs && pend[rs] == 1) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic we,
                                          input logic [4:0] wrd, input logic [31:0] wdat);
    if (rs == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (we && wrd == rs) return wdat;
`endif
    return regs[rs];
  endfunction

  // One clock: drive, check hazard, clock, check execute register, update model.
  task automatic step(input desc_t d, input logic we, input logic [4:0] wrd,
                      input logic [31:0] wdat, input logic r, output logic acc);
    logic        u1, u2, wr, valid, eh, iss, rwe;
    logic [31:0] e1, e2, inst;
    rst = r; if_pc = d.pc; if_inst = d.inst;
    wb_we = we; wb_rd = wrd; wb_data = wdat;
    inst  = d.inst;
    valid = (d.kind != K_NONE);
    u1    = d.kind inside {K_I, K_B, K_S, K_R};
    u2    = d.kind inside {K_B, K_S, K_R};
    wr    = d.kind inside {K_U, K_J, K_I, K_R};
    eh    = (u1 && blocked(d.rs1, we, wrd)) || (u2 && blocked(d.rs2, we, wrd)) ||
            (wr && d.rd != 5'd0 && pend[d.rd] == PMAX);
    iss   = valid && !eh && !r;
    rwe   = iss && wr && (d.rd != 5'd0);
    e1    = u1 ? operand(d.rs1, we, wrd, wdat) : 32'd0;
    e2    = u2 ? operand(d.rs2, we, wrd, wdat) : 32'd0;
    #1;
    chk("data_hazard", {31'd0, data_hazard}, {31'd0, eh});
    @(posedge clk);
    #1;
    chk("ex_valid",    {31'd0, ex_valid},    {31'd0, iss});
    chk("ex_pc",       ex_pc,                iss ? d.pc : 32'd0);
    chk("ex_opcode",   {25'd0, ex_opcode},   iss ? {25'd0, inst[6:0]} : 32'd0);
    chk("ex_funct3",   {29'd0, ex_funct3},   iss ? {29'd0, inst[14:12]} : 32'd0);
    chk("ex_funct7b5", {31'd0, ex_funct7b5}, iss ? {31'd0, inst[30]} : 32'd0);
    chk("ex_rd",       {27'd0, ex_rd},       rwe ? {27'd0, d.rd} : 32'd0);
    chk("ex_reg_we",   {31'd0, ex_reg_we},   {31'd0, rwe});
    chk("ex_rs1_data", ex_rs1_data,          iss ? e1 : 32'd0);
    chk("ex_rs2_data", ex_rs2_data,          iss ? e2 : 32'd0);
    chk("ex_imm",      ex_imm,               iss ? d.imm : 32'd0);
    if (r) begin
      for (int i = 0; i < 32; i++) begin regs[i] = '0; pend[i] = 0; end
      inflight.delete();
    end else begin
      for (int i = 1; i < 32; i++) begin
        logic inc, dec;
        inc = rwe && (d.rd == 5'(i));
        dec = we && (wrd == 5'(i));
        if (inc && !dec) pend[i]++;
        else if (!inc && dec && pend[i] > 0) pend[i]--;
      end
      if (we && wrd != 5'd0) regs[wrd] = wdat;
      if (rwe) inflight.push_back(d.rd);
    end
    acc = !eh;
  endtask

  initial begin
    desc_t       nop, d, d3, d4, dx;
    logic        acc, we;
    logic [4:0]  wrd;
    logic [31:0] wdat, pc;

    for (int i = 0; i < 32; i++) begin regs[i] = '0; pend[i] = 0; end
    rst = 1'b1; if_pc = '0; if_inst = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    nop = mk(K_NONE, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    @(posedge clk); #1;

    // reset
    step(nop, 1'b0, 5'd0, 32'd0, 1'b1, acc);
    step(nop, 1'b0, 5'd0, 32'd0, 1'b1, acc);
    chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);

    // addi x1,x0,5
    d = mk(K_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    d.inst = 32'h00500093; d.pc = 32'd0;
    step(d, 1'b0, 5'd0, 32'd0, 1'b0, acc);
    chk("addi_valid", {31'd0, ex_valid}, 32'd1);
    chk("addi_rd",    {27'd0, ex_rd}, 32'd1);
    chk("addi_imm",   ex_imm, 32'd5);
    chk("addi_rs1",   ex_rs1_data, 32'd0);

    // add x2,x1,x1 stalls until x1 writes back
    d = mk(K_R, 7'h33, 5'd2, 5'd1, 5'd1, 3'd0, 32'd0);
    d.inst = 32'h00108133; d.pc = 32'd4;
    step(d, 1'b0, 5'd0, 32'd0, 1'b0, acc);
    step(d, 1'b0, 5'd0, 32'd0, 1'b0, acc);
    chk("add_stall_haz",   {31'd0, data_hazard}, 32'd1);
    chk("add_stall_valid", {31'd0, ex_valid}, 32'd0);
    step(d, 1'b1, 5'd1, 32'd5, 1'b0, acc);
    if (!acc) step(d, 1'b0, 5'd0, 32'd0, 1'b0, acc);
    chk("add_valid", {31'd0, ex_valid}, 32'd1);
    chk("add_rs1",   ex_rs1_data, 32'd5);
    chk("add_rs2",   ex_rs2_data, 32'd5);

    // bubble
    step(nop, 1'b0, 5'd0, 32'd0, 1'b0, acc);
    chk("bubble_valid",  {31'd0, ex_valid}, 32'd0);
    chk("bubble_hazard", {31'd0, data_hazard}, 32'd0);

    // saturate x3 then retire one
    d3 = mk(K_I, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'd7); d3.pc = 32'd8;
    repeat (3) step(d3, 1'b0, 5'd0, 32'd0, 1'b0, acc);
    step(d3, 1'b0, 5'd0, 32'd0, 1'b0, acc);
    chk("sat_x3_haz", {31'd0, data_hazard}, 32'd1);
    step(d3, 1'b1, 5'd3, 32'h33, 1'b0, acc);
    step(d3, 1'b0, 5'd0, 32'd0, 1'b0, acc);

    // issue and writeback to x4 in the same cycle keep the count at 1
    d4 = mk(K_I, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 32'hfff); d4.pc = 32'd12;
    step(d4, 1'b0, 5'd0, 32'd0, 1'b0, acc);
    step(d4, 1'b1, 5'd4, 32'h44, 1'b0, acc);
    step(d4, 1'b0, 5'd0, 32'd0, 1'b0, acc);
    step(d4, 1'b0, 5'd0, 32'd0, 1'b0, acc);
    step(d4, 1'b0, 5'd0, 32'd0, 1'b0, acc);
    chk("cnt4_full_haz", {31'd0, data_hazard}, 32'd1);

    // sw x1,8(x2)
    step(nop, 1'b1, 5'd2, 32'h100, 1'b0, acc);
    d = mk(K_S, 7'h23, 5'd0, 5'd2, 5'd1, 3'd2, 32'd8);
    d.inst = 32'h00112423; d.pc = 32'd16;
    step(d, 1'b0, 5'd0, 32'd0, 1'b0, acc);
    chk("sw_reg_we", {31'd0, ex_reg_we}, 32'd0);
    chk("sw_rd",     {27'd0, ex_rd}, 32'd0);
    chk("sw_imm",    ex_imm, 32'd8);
    chk("sw_rs1",    ex_rs1_data, 32'h100);
    chk("sw_rs2",    ex_rs2_data, 32'd5);

    // reset in the middle of a stall on x3
    dx = mk(K_R, 7'h33, 5'd5, 5'd3, 5'd3, 3'd0, 32'h40000000); dx.pc = 32'd20;
    step(dx, 1'b0, 5'd0, 32'd0, 1'b0, acc);
    step(dx, 1'b0, 5'd0, 32'd0, 1'b1, acc);
    chk("rst_mid_valid",  {31'd0, ex_valid}, 32'd0);
    chk("rst_mid_hazard", {31'd0, data_hazard}, 32'd0);
    step(dx, 1'b0, 5'd0, 32'd0, 1'b0, acc);
    step(nop, 1'b0, 5'd0, 32'd0, 1'b1, acc);

    // random traffic with in-order writebacks of issued destinations
    pc = 32'h1000;
    d = gen(); d.pc = pc;
    for (int n = 0; n < 3000; n++) begin
      we = 1'b0; wrd = 5'd0; wdat = $urandom;
      if (inflight.size() > 0 && $urandom_range(0, 2) != 0) begin
        we = 1'b1; wrd = inflight.pop_front();
      end else if ($urandom_range(0, 15) == 0) begin
        we = 1'b1; wrd = 5'd0;
      end
      step(d, we, wrd, wdat, 1'b0, acc);
      if (acc) begin
        pc = pc + 32'd4;
        d = gen(); d.pc = pc;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
